// File: rtl/exception_unit_pkg.sv
// Shared CP0 exception definitions: MMU cause codes, ExcCode values,
// Status/Cause bit positions and the exception-unit FSM encoding.
package exception_unit_pkg;

    localparam int MMU_EXC_W = 4;

    localparam logic [2:0] MMU_NONE = 3'd0;
    localparam logic [2:0] MMU_MOD  = 3'd1;
    localparam logic [2:0] MMU_TLBL = 3'd2;
    localparam logic [2:0] MMU_TLBS = 3'd3;
    localparam logic [2:0] MMU_ADEL = 3'd4;
    localparam logic [2:0] MMU_ADES = 3'd5;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_HW_LO  = 10;
    localparam int CA_BD     = 31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_COMMIT,
        S_REDIRECT
    } exc_state_t;

    // Only the MMU-originated causes carry a faulting address
    function automatic logic has_badvaddr(input logic [4:0] code);
        return (code >= EXC_MOD) && (code <= EXC_ADES);
    endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Commit-stage, CP0 writeback and fetch-redirect signals of the exception unit.
interface exception_unit_if #(
    parameter int NUM_IRQ = 6
);
    logic               exc_valid;
    logic [31:0]        exc_pc;
    logic               exc_bd;
    logic [3:0]         mmu_exc;
    logic [31:0]        bad_vaddr;
    logic               syscall;
    logic               brk;
    logic               eret;
    logic [NUM_IRQ-1:0] irq;
    logic [31:0]        cp0_status;
    logic [31:0]        cp0_cause;
    logic [31:0]        cp0_epc;
    logic               flush;
    logic               drained;
    logic               we_status;
    logic               we_cause;
    logic               we_epc;
    logic               we_badvaddr;
    logic [31:0]        out_status;
    logic [31:0]        out_cause;
    logic [31:0]        out_epc;
    logic [31:0]        out_badvaddr;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               redirect_ready;
    logic               busy;

    modport slave (
        input  exc_valid, exc_pc, exc_bd, mmu_exc, bad_vaddr, syscall, brk, eret, irq,
               cp0_status, cp0_cause, cp0_epc, drained, redirect_ready,
        output flush, we_status, we_cause, we_epc, we_badvaddr,
               out_status, out_cause, out_epc, out_badvaddr,
               redirect_valid, redirect_pc, busy
    );

    modport master (
        output exc_valid, exc_pc, exc_bd, mmu_exc, bad_vaddr, syscall, brk, eret, irq,
               cp0_status, cp0_cause, cp0_epc, drained, redirect_ready,
        input  flush, we_status, we_cause, we_epc, we_badvaddr,
               out_status, out_cause, out_epc, out_badvaddr,
               redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/exception_unit_prio.sv
// Combinational cause arbitration: interrupt > MMU > syscall > break > ERET.
module exc_priority_enc
    import exception_unit_pkg::*;
(
    input  logic       i_exc_valid,
    input  logic       i_int_pend,
    input  logic [3:0] i_mmu_exc,
    input  logic       i_syscall,
    input  logic       i_brk,
    input  logic       i_eret,
    output logic       o_take,
    output logic [4:0] o_code,
    output logic       o_refill,
    output logic       o_is_eret
);

    always_comb begin
        o_take    = 1'b0;
        o_code    = EXC_INT;
        o_refill  = 1'b0;
        o_is_eret = 1'b0;
        // Interrupts do not need a valid committing instruction
        if (i_int_pend) begin
            o_take = 1'b1;
            o_code = EXC_INT;
        end else if (i_exc_valid) begin
            if (i_mmu_exc != 4'd0) begin
                o_take   = 1'b1;
                o_code   = {2'b00, i_mmu_exc[2:0]};
                o_refill = i_mmu_exc[3];
            end else if (i_syscall) begin
                o_take = 1'b1;
                o_code = EXC_SYS;
            end else if (i_brk) begin
                o_take = 1'b1;
                o_code = EXC_BP;
            end else if (i_eret) begin
                o_take    = 1'b1;
                o_is_eret = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Precise-exception controller: arbitrates commit-stage causes, then sequences
// pipeline flush, CP0 writeback and the PC redirect (exceptions and ERET).
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter int          NUM_IRQ    = 6,
    parameter logic [31:0] EXC_BASE   = 32'h8000_0000,
    parameter logic [31:0] GEN_OFFSET = 32'h0000_0180
) (
    input  logic             clk,
    input  logic             rst,
    exception_unit_if.slave  bus
);

    exc_state_t         r_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [4:0]         r_code;
    logic [31:0]        r_pc;
    logic               r_bd;
    logic [31:0]        r_vaddr;
    logic               r_is_eret;
    logic               r_refill;
    logic [5:0]         r_irq_lat;
    logic               r_old_exl;

    logic               r_flush;
    logic               r_we_status, r_we_cause, r_we_epc, r_we_badvaddr;
    logic [31:0]        r_out_status, r_out_cause, r_out_epc, r_out_badvaddr;
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;
    logic               r_busy;

    logic [7:0]         w_ip;
    logic [5:0]         w_hw_ip;
    logic               w_int_pend;
    logic               w_take, w_refill, w_is_eret;
    logic [4:0]         w_code;
    logic [31:0]        w_cause_new;
    logic [31:0]        w_epc_new;
    logic [31:0]        w_exc_target;

    always_comb begin
        w_ip                      = '0;
        w_ip[1:0]                 = bus.cp0_cause[CA_IP_LO+1:CA_IP_LO];
        w_ip[NUM_IRQ+1:2]         = r_irq_q;
        w_hw_ip                   = '0;
        w_hw_ip[NUM_IRQ-1:0]      = r_irq_q;
    end

    assign w_int_pend = bus.cp0_status[ST_IE] & ~bus.cp0_status[ST_EXL]
                      & (|(w_ip & bus.cp0_status[ST_IM_LO+7:ST_IM_LO]));

    exc_priority_enc u_prio (
        .i_exc_valid (bus.exc_valid),
        .i_int_pend  (w_int_pend),
        .i_mmu_exc   (bus.mmu_exc),
        .i_syscall   (bus.syscall),
        .i_brk       (bus.brk),
        .i_eret      (bus.eret),
        .o_take      (w_take),
        .o_code      (w_code),
        .o_refill    (w_refill),
        .o_is_eret   (w_is_eret)
    );

    always_comb begin
        w_cause_new                          = bus.cp0_cause;
        w_cause_new[CA_EXC_LO+4:CA_EXC_LO]   = r_code;
        w_cause_new[CA_HW_LO+5:CA_HW_LO]     = r_irq_lat;
        w_cause_new[CA_BD]                   = r_bd;
    end

    assign w_epc_new    = r_bd ? (r_pc - 32'd4) : r_pc;
    assign w_exc_target = EXC_BASE + ((r_refill & ~r_old_exl) ? 32'd0 : GEN_OFFSET);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_irq_q          <= '0;
            r_code           <= '0;
            r_pc             <= '0;
            r_bd             <= 1'b0;
            r_vaddr          <= '0;
            r_is_eret        <= 1'b0;
            r_refill         <= 1'b0;
            r_irq_lat        <= '0;
            r_old_exl        <= 1'b0;
            r_flush          <= 1'b0;
            r_we_status      <= 1'b0;
            r_we_cause       <= 1'b0;
            r_we_epc         <= 1'b0;
            r_we_badvaddr    <= 1'b0;
            r_out_status     <= '0;
            r_out_cause      <= '0;
            r_out_epc        <= '0;
            r_out_badvaddr   <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_busy           <= 1'b0;
        end else begin
            r_irq_q <= bus.irq;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_code    <= w_code;
                        r_pc      <= bus.exc_pc;
                        r_bd      <= bus.exc_valid & bus.exc_bd;
                        r_vaddr   <= bus.bad_vaddr;
                        r_is_eret <= w_is_eret;
                        r_refill  <= w_refill;
                        r_irq_lat <= w_hw_ip;
                        r_flush   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_FLUSH;
                    end
                end
                // Strobes are registered, so the COMMIT-cycle write data is built here
                S_FLUSH: begin
                    if (bus.drained) begin
                        r_flush     <= 1'b0;
                        r_old_exl   <= bus.cp0_status[ST_EXL];
                        r_we_status <= 1'b1;
                        if (r_is_eret) begin
                            r_out_status <= bus.cp0_status & ~32'd2;
                        end else begin
                            r_out_status <= bus.cp0_status | 32'd2;
                            r_we_cause   <= 1'b1;
                            r_out_cause  <= w_cause_new;
                            if (!bus.cp0_status[ST_EXL]) begin
                                r_we_epc  <= 1'b1;
                                r_out_epc <= w_epc_new;
                            end
                            if (has_badvaddr(r_code)) begin
                                r_we_badvaddr  <= 1'b1;
                                r_out_badvaddr <= r_vaddr;
                            end
                        end
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_we_status      <= 1'b0;
                    r_we_cause       <= 1'b0;
                    r_we_epc         <= 1'b0;
                    r_we_badvaddr    <= 1'b0;
                    r_out_status     <= '0;
                    r_out_cause      <= '0;
                    r_out_epc        <= '0;
                    r_out_badvaddr   <= '0;
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= r_is_eret ? bus.cp0_epc : w_exc_target;
                    r_state          <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_redirect_pc    <= '0;
                        r_busy           <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.flush          = r_flush;
    assign bus.we_status      = r_we_status;
    assign bus.we_cause       = r_we_cause;
    assign bus.we_epc         = r_we_epc;
    assign bus.we_badvaddr    = r_we_badvaddr;
    assign bus.out_status     = r_out_status;
    assign bus.out_cause      = r_out_cause;
    assign bus.out_epc        = r_out_epc;
    assign bus.out_badvaddr   = r_out_badvaddr;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: interrupt, MMU refill, priority, ERET
// and mid-flush reset scenarios with hand-computed CP0/redirect values.
module tb_exception_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exception_unit_if #(.NUM_IRQ(6)) bus ();

    exception_unit #(
        .NUM_IRQ    (6),
        .EXC_BASE   (32'h8000_0000),
        .GEN_OFFSET (32'h0000_0180)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearEvent();
        bus.exc_valid = 1'b0;
        bus.exc_bd    = 1'b0;
        bus.mmu_exc   = 4'd0;
        bus.syscall   = 1'b0;
        bus.brk       = 1'b0;
        bus.eret      = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.redirect_ready = 1'b1;
        step();
        checkOutput({tag, " idle busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, " idle rv"}, {31'd0, bus.redirect_valid}, 32'd0);
        bus.redirect_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clearEvent();
        bus.exc_pc         = '0;
        bus.bad_vaddr      = '0;
        bus.irq            = '0;
        bus.cp0_status     = '0;
        bus.cp0_cause      = '0;
        bus.cp0_epc        = '0;
        bus.drained        = 1'b0;
        bus.redirect_ready = 1'b0;
        step();
        step();
        checkOutput("rst flush",  {31'd0, bus.flush}, 32'd0);
        checkOutput("rst busy",   {31'd0, bus.busy}, 32'd0);
        checkOutput("rst we_st",  {31'd0, bus.we_status}, 32'd0);
        checkOutput("rst rv",     {31'd0, bus.redirect_valid}, 32'd0);
        checkOutput("rst rpc",    bus.redirect_pc, 32'd0);
        checkOutput("rst ostat",  bus.out_status, 32'd0);
        rst = 1'b0;
        step();

        // Interrupt on irq[0], drained arrives late
        bus.cp0_status = 32'h0000_0401;
        bus.exc_pc     = 32'hBFC0_0100;
        bus.irq        = 6'b000001;
        step();
        checkOutput("t1 not yet busy", {31'd0, bus.busy}, 32'd0);
        step();
        bus.irq = '0;
        checkOutput("t1 flush c1", {31'd0, bus.flush}, 32'd1);
        checkOutput("t1 busy", {31'd0, bus.busy}, 32'd1);
        step();
        checkOutput("t1 flush c2", {31'd0, bus.flush}, 32'd1);
        step();
        checkOutput("t1 flush c3", {31'd0, bus.flush}, 32'd1);
        bus.drained = 1'b1;
        step();
        bus.drained = 1'b0;
        checkOutput("t1 flush off", {31'd0, bus.flush}, 32'd0);
        checkOutput("t1 we_status", {31'd0, bus.we_status}, 32'd1);
        checkOutput("t1 status",    bus.out_status, 32'h0000_0403);
        checkOutput("t1 we_cause",  {31'd0, bus.we_cause}, 32'd1);
        checkOutput("t1 cause",     bus.out_cause, 32'h0000_0400);
        checkOutput("t1 we_epc",    {31'd0, bus.we_epc}, 32'd1);
        checkOutput("t1 epc",       bus.out_epc, 32'hBFC0_0100);
        checkOutput("t1 we_bva",    {31'd0, bus.we_badvaddr}, 32'd0);
        step();
        checkOutput("t1 strobe off", {31'd0, bus.we_status}, 32'd0);
        checkOutput("t1 rv",  {31'd0, bus.redirect_valid}, 32'd1);
        checkOutput("t1 rpc", bus.redirect_pc, 32'h8000_0180);
        bus.cp0_status = 32'h0;
        handshake("t1");

        // TLBL refill in a delay slot, EXL clear, drained already high
        bus.drained   = 1'b1;
        bus.exc_valid = 1'b1;
        bus.exc_pc    = 32'h0000_2004;
        bus.exc_bd    = 1'b1;
        bus.mmu_exc   = 4'b1010;
        bus.bad_vaddr = 32'h0040_1000;
        step();
        clearEvent();
        checkOutput("t2 min flush", {31'd0, bus.flush}, 32'd1);
        step();
        checkOutput("t2 cause",  bus.out_cause, 32'h8000_0008);
        checkOutput("t2 epc",    bus.out_epc, 32'h0000_2000);
        checkOutput("t2 we_epc", {31'd0, bus.we_epc}, 32'd1);
        checkOutput("t2 we_bva", {31'd0, bus.we_badvaddr}, 32'd1);
        checkOutput("t2 bva",    bus.out_badvaddr, 32'h0040_1000);
        checkOutput("t2 status", bus.out_status, 32'h0000_0002);
        step();
        checkOutput("t2 rpc", bus.redirect_pc, 32'h8000_0000);
        handshake("t2");

        // Same refill with EXL already set: no EPC write, general vector
        bus.cp0_status = 32'h0000_0002;
        bus.exc_valid  = 1'b1;
        bus.exc_bd     = 1'b1;
        bus.mmu_exc    = 4'b1010;
        step();
        clearEvent();
        step();
        checkOutput("t3 we_epc", {31'd0, bus.we_epc}, 32'd0);
        checkOutput("t3 epc data zero", bus.out_epc, 32'd0);
        checkOutput("t3 we_bva", {31'd0, bus.we_badvaddr}, 32'd1);
        checkOutput("t3 status", bus.out_status, 32'h0000_0002);
        step();
        checkOutput("t3 rpc", bus.redirect_pc, 32'h8000_0180);
        bus.cp0_status = 32'h0;
        handshake("t3");

        // Interrupt beats syscall and break in the same cycle
        bus.irq = 6'b000001;
        step();
        bus.cp0_status = 32'h0000_0401;
        bus.exc_valid  = 1'b1;
        bus.exc_pc     = 32'h0000_3000;
        bus.syscall    = 1'b1;
        bus.brk        = 1'b1;
        step();
        clearEvent();
        bus.irq        = '0;
        bus.cp0_status = 32'h0;
        step();
        checkOutput("t4 int cause", bus.out_cause, 32'h0000_0400);
        checkOutput("t4 int epc",   bus.out_epc, 32'h0000_3000);
        step();
        checkOutput("t4 int rpc", bus.redirect_pc, 32'h8000_0180);
        handshake("t4a");

        // Syscall beats break
        bus.exc_valid = 1'b1;
        bus.exc_pc    = 32'h0000_3004;
        bus.syscall   = 1'b1;
        bus.brk       = 1'b1;
        step();
        clearEvent();
        step();
        checkOutput("t4 sys cause", bus.out_cause, 32'h0000_0020);
        checkOutput("t4 sys we_bva", {31'd0, bus.we_badvaddr}, 32'd0);
        step();
        handshake("t4b");

        // ERET with a slow fetch acceptor
        bus.cp0_status = 32'h0000_0403;
        bus.cp0_epc    = 32'h0040_0020;
        bus.exc_valid  = 1'b1;
        bus.eret       = 1'b1;
        step();
        clearEvent();
        step();
        checkOutput("t5 we_status", {31'd0, bus.we_status}, 32'd1);
        checkOutput("t5 status",    bus.out_status, 32'h0000_0401);
        checkOutput("t5 we_cause",  {31'd0, bus.we_cause}, 32'd0);
        checkOutput("t5 we_epc",    {31'd0, bus.we_epc}, 32'd0);
        step();
        bus.cp0_epc = 32'hDEAD_0000;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t5 hold rv",  {31'd0, bus.redirect_valid}, 32'd1);
            checkOutput("t5 hold rpc", bus.redirect_pc, 32'h0040_0020);
            step();
        end
        bus.cp0_status = 32'h0;
        handshake("t5");

        // Reset during FLUSH abandons the event
        bus.drained   = 1'b0;
        bus.exc_valid = 1'b1;
        bus.syscall   = 1'b1;
        step();
        clearEvent();
        checkOutput("t6 flush", {31'd0, bus.flush}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.drained = 1'b1;
        checkOutput("t6 flush off", {31'd0, bus.flush}, 32'd0);
        checkOutput("t6 busy",      {31'd0, bus.busy}, 32'd0);
        checkOutput("t6 we_status", {31'd0, bus.we_status}, 32'd0);
        checkOutput("t6 rv",        {31'd0, bus.redirect_valid}, 32'd0);
        step();
        step();
        checkOutput("t6 no late strobe", {31'd0, bus.we_status}, 32'd0);
        checkOutput("t6 still idle",     {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Parametrised precise-exception controller for the CPU's CP0 path; next generation of the combinational exception decoder.
- Arbitrates interrupt, MMU, syscall and break causes at the commit stage and latches the cause.
- Sequences pipeline flush, the CP0 Status/Cause/EPC/BadVAddr writeback and the PC redirect to the vector; also handles ERET.

Parameters:
- NUM_IRQ, 6, number of hardware interrupt lines mapped to Cause.IP[2+NUM_IRQ-1:2]; legal range 1..6.
- EXC_BASE, 32'h8000_0000, exception vector base.
- GEN_OFFSET, 32'h180, general-vector offset; TLB refill uses offset 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exc_valid  in  1  commit-stage instruction valid this cycle
- exc_pc  in  32  PC of the committing instruction
- exc_bd  in  1  instruction is in a branch delay slot
- mmu_exc  in  4  [3] refill flag, [2:0] code: 0 none, 1 Mod, 2 TLBL, 3 TLBS, 4 AdEL, 5 AdES
- bad_vaddr  in  32  faulting address for MMU causes
- syscall  in  1  syscall committing
- brk  in  1  break committing
- eret  in  1  ERET committing
- irq  in  NUM_IRQ  level-sensitive interrupt lines
- cp0_status, cp0_cause, cp0_epc  in  32  current CP0 values
- flush  out  1  kill all pipeline stages
- drained  in  1  pipeline empty, acknowledges flush
- we_status, we_cause, we_epc, we_badvaddr  out  1  one-cycle CP0 write strobes
- out_status, out_cause, out_epc, out_badvaddr  out  32  CP0 write data
- redirect_valid  out  1  new PC available
- redirect_pc  out  32  target PC
- redirect_ready  in  1  fetch accepts the redirect
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM to IDLE, irq_q=0, every output 0.
- irq registered once per cycle into irq_q.
- ip = {irq_q, cp0_cause[9:8]}, zero-extended into the 8-bit field.
- int_pend = Status.IE(bit0) & ~Status.EXL(bit1) & |(ip & Status.IM[15:8]).
- Priority when exc_valid=1 in IDLE: int_pend > mmu_exc!=0 > syscall > brk > eret.
  - ExcCode values: Int 0, Mod 1, TLBL 2, TLBS 3, AdEL 4, AdES 5, Sys 8, Bp 9.
  - int_pend is evaluated even when exc_valid=0; in that case the interrupt takes EPC = exc_pc.
- Exception and eret in the same cycle: the exception wins and eret is dropped.
- FSM states:
  - IDLE: on an accepted event, latch code, pc, bd, vaddr and kind (exc or eret); go to FLUSH.
  - FLUSH: flush=1 until sampling drained=1, then go to COMMIT. Minimum one FLUSH cycle; drained already high still costs one cycle.
  - COMMIT (exactly 1 cycle):
    - For an exception, pulse we_status and we_cause; pulse we_epc unless Status.EXL was already 1. Pulse we_badvaddr only for codes 1-5.
    - out_cause = cp0_cause with [6:2]=code, [15:10]=irq_q, [31]=bd; other bits preserved.
    - out_epc = bd ? pc-4 : pc, computed mod 2^32.
    - out_status = cp0_status | 2.
    - For ERET: pulse we_status only, with out_status = cp0_status & ~2. Then go to REDIRECT.
  - REDIRECT: redirect_valid=1, with redirect_pc held stable, until redirect_ready=1 is sampled; then go to IDLE.
    - ERET target: cp0_epc sampled in COMMIT.
    - Exception target: EXC_BASE + ((refill & ~old EXL) ? 0 : GEN_OFFSET).
- busy=1 in FLUSH, COMMIT and REDIRECT. All inputs except drained, redirect_ready and irq are ignored while busy.
- Back-to-back: the earliest new acceptance is the cycle after the REDIRECT handshake completes.
- Reset mid-operation: abandon the event, no CP0 strobes, all outputs 0 on the next cycle.
- Write data is valid only while its strobe is high; data outputs are otherwise 0.

Decomposition:
- Shared header (alongside the MMU definitions):
  - MMU exception code constants and width.
  - ExcCode constants.
  - Status/Cause bit positions (IE, EXL, IM, IP, BD, ExcCode field).
  - FSM state encoding.
- One sub-module, exc_priority_enc: combinational cause arbitration producing {take, code, refill, is_eret}. The FSM stays in exception_unit.

Test Plan:
- Status=32'h0000_0401, irq[0]=1 for 2 cycles, exc_pc=32'hBFC0_0100, drained 3 cycles late. Required: flush held 3 cycles; COMMIT gives Cause[6:2]=0, Cause[10]=1, EPC=32'hBFC0_0100, Status=32'h0000_0403; redirect_pc=32'h8000_0180.
- mmu_exc=4'b1010 (TLBL refill), bad_vaddr=32'h0040_1000, exc_bd=1, pc=32'h0000_2004, EXL=0. Required: code 2, Cause[31]=1, EPC=32'h0000_2000, BadVAddr written, redirect_pc=32'h8000_0000.
- Same refill with EXL=1. Required: we_epc=0, redirect_pc=32'h8000_0180.
- syscall, brk and an enabled IRQ in the same cycle. Required: code 0. Then syscall+brk alone. Required: code 8.
- eret with cp0_epc=32'h0040_0020 and Status=32'h0000_0403. Required: Status=32'h0000_0401, redirect_pc=32'h0040_0020; redirect_ready held low 4 cycles keeps redirect_valid high and pc stable.
- rst asserted during FLUSH. Required: next cycle all outputs 0, no strobes, busy=0.
